// File: rtl/race_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : race_game_ctrl
// Brief   : Pixel merge, car/obstacle collision detect and game FSM
//           (idle / play / crash / game over) with lives and score.
// Revision: 1.0 - initial release
// ============================================================================
module race_game_ctrl #(
    parameter int          LIVES_INIT   = 3,
    parameter int          CRASH_FRAMES = 60,
    parameter int          SCORE_DIV    = 30,
    parameter int          SCORE_MAX    = 9999,
    parameter logic [11:0] CRASH_RGB    = 12'hF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refresh_tick,
    input  logic        video_on,
    input  logic        start_key,
    input  logic        car_on,
    input  logic [11:0] car_rgb,
    input  logic        obst_on,
    input  logic [11:0] obst_rgb,
    input  logic [11:0] bg_rgb,
    output logic [11:0] rgb,
    output logic        pause,
    output logic        game_reset,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic        game_over
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PLAY  = 2'd1;
    localparam logic [1:0] c_ST_CRASH = 2'd2;
    localparam logic [1:0] c_ST_OVER  = 2'd3;

    localparam int c_CRASH_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;
    localparam int c_DIV_W   = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

    localparam logic [c_CRASH_W-1:0] c_CRASH_LAST = c_CRASH_W'(CRASH_FRAMES - 1);
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST   = c_DIV_W'(SCORE_DIV - 1);
    localparam logic [13:0]          c_SCORE_MAX  = 14'(SCORE_MAX);
    localparam logic [1:0]           c_LIVES_INIT = 2'(LIVES_INIT);

    logic [1:0]           r_state;
    logic                 r_start_q;
    logic                 r_hit;
    logic [c_CRASH_W-1:0] r_crash_cnt;
    logic [3:0]           r_flash_cnt;
    logic [c_DIV_W-1:0]   r_score_div;
    logic [1:0]           r_lives;
    logic [13:0]          r_score;
    logic [11:0]          r_rgb;
    logic                 r_pause;
    logic                 r_game_reset;
    logic                 r_game_over;

    logic [1:0]           w_state_nxt;
    logic [c_CRASH_W-1:0] w_crash_cnt_nxt;
    logic [3:0]           w_flash_cnt_nxt;
    logic [c_DIV_W-1:0]   w_score_div_nxt;
    logic [1:0]           w_lives_nxt;
    logic [13:0]          w_score_nxt;
    logic                 w_game_reset_nxt;
    logic                 w_hit_nxt;
    logic [11:0]          w_rgb_nxt;
    logic                 w_start_edge;
    logic                 w_overlap;

    assign w_start_edge = start_key & ~r_start_q;
    assign w_overlap    = video_on & car_on & obst_on;

    // Car wins over obstacle; during a crash the car flashes on flash_cnt[3].
    always_comb begin
        w_rgb_nxt = bg_rgb;
        if (!video_on) begin
            w_rgb_nxt = 12'h000;
        end else if (car_on) begin
            if ((r_state == c_ST_CRASH) && r_flash_cnt[3]) begin
                w_rgb_nxt = CRASH_RGB;
            end else begin
                w_rgb_nxt = car_rgb;
            end
        end else if (obst_on) begin
            w_rgb_nxt = obst_rgb;
        end
    end

    // The FSM sees the flag accumulated over the previous frame; the flag is
    // then reloaded with this cycle's overlap so nothing falls between frames.
    always_comb begin
        w_hit_nxt = r_hit | w_overlap;
        if (refresh_tick) begin
            w_hit_nxt = w_overlap;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_crash_cnt_nxt  = r_crash_cnt;
        w_flash_cnt_nxt  = r_flash_cnt;
        w_score_div_nxt  = r_score_div;
        w_lives_nxt      = r_lives;
        w_score_nxt      = r_score;
        w_game_reset_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt      = c_ST_PLAY;
                    w_lives_nxt      = c_LIVES_INIT;
                    w_score_nxt      = 14'd0;
                    w_score_div_nxt  = '0;
                    w_game_reset_nxt = 1'b1;
                end
            end
            c_ST_PLAY: begin
                if (refresh_tick) begin
                    if (r_hit) begin
                        w_state_nxt     = c_ST_CRASH;
                        w_crash_cnt_nxt = '0;
                        w_flash_cnt_nxt = 4'd0;
                    end else if (r_score_div == c_DIV_LAST) begin
                        w_score_div_nxt = '0;
                        if (r_score != c_SCORE_MAX) begin
                            w_score_nxt = r_score + 14'd1;
                        end
                    end else begin
                        w_score_div_nxt = r_score_div + 1'b1;
                    end
                end
            end
            c_ST_CRASH: begin
                if (refresh_tick) begin
                    w_crash_cnt_nxt = r_crash_cnt + 1'b1;
                    w_flash_cnt_nxt = r_flash_cnt + 4'd1;
                    if (r_crash_cnt == c_CRASH_LAST) begin
                        if (r_lives <= 2'd1) begin
                            w_lives_nxt = 2'd0;
                            w_state_nxt = c_ST_OVER;
                        end else begin
                            w_lives_nxt      = r_lives - 2'd1;
                            w_state_nxt      = c_ST_PLAY;
                            w_game_reset_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (w_start_edge) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_start_q    <= 1'b0;
            r_hit        <= 1'b0;
            r_crash_cnt  <= '0;
            r_flash_cnt  <= 4'd0;
            r_score_div  <= '0;
            r_lives      <= c_LIVES_INIT;
            r_score      <= 14'd0;
            r_rgb        <= 12'h000;
            r_pause      <= 1'b1;
            r_game_reset <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_q    <= start_key;
            r_hit        <= w_hit_nxt;
            r_crash_cnt  <= w_crash_cnt_nxt;
            r_flash_cnt  <= w_flash_cnt_nxt;
            r_score_div  <= w_score_div_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_rgb        <= w_rgb_nxt;
            r_pause      <= (w_state_nxt != c_ST_PLAY);
            r_game_reset <= w_game_reset_nxt;
            r_game_over  <= (w_state_nxt == c_ST_OVER);
        end
    end

    assign rgb        = r_rgb;
    assign pause      = r_pause;
    assign game_reset = r_game_reset;
    assign lives      = r_lives;
    assign score      = r_score;
    assign game_over  = r_game_over;

endmodule
`default_nettype wire
